uart_alu_interface: RTL and testbench

Sequencer between the UART receiver/transmitter and the ALU in the TP3 datapath.
- Collects three received bytes from UART RX, in order: operand 1, operand 2, opcode.
- Drives them as registered ALU inputs.
- Captures the combinational ALU result one cycle later and hands it to UART TX with a start/done handshake.
- Aborts partial frames on an inactivity timeout and flags bytes that arrive while the block is busy.

---
 rtl/uart_alu_interface_pkg.sv | 25 ++
 rtl/uart_alu_interface_timeout_counter.sv | 41 ++++
 rtl/uart_alu_interface.sv | 116 +++++++++++
 tb/tb_uart_alu_interface.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_interface_pkg.sv
// Shared constants for the UART <-> ALU sequencer: data widths, sequencer
// states and the opcode values understood by the TP3 ALU.
package uart_alu_interface_pkg;

  localparam int CANT_BUS_DATOS   = 8;
  localparam int CANT_BITS_OPCODE = 8;

  typedef enum logic [2:0] {
    ESPERA_OP1,
    ESPERA_OP2,
    ESPERA_OPCODE,
    CALCULO,
    ESPERA_TX
  } estado_t;

  localparam logic [CANT_BITS_OPCODE-1:0] OP_ADD = 8'h20;
  localparam logic [CANT_BITS_OPCODE-1:0] OP_SUB = 8'h22;
  localparam logic [CANT_BITS_OPCODE-1:0] OP_AND = 8'h24;
  localparam logic [CANT_BITS_OPCODE-1:0] OP_OR  = 8'h25;
  localparam logic [CANT_BITS_OPCODE-1:0] OP_XOR = 8'h26;
  localparam logic [CANT_BITS_OPCODE-1:0] OP_SRA = 8'h03;
  localparam logic [CANT_BITS_OPCODE-1:0] OP_SRL = 8'h02;
  localparam logic [CANT_BITS_OPCODE-1:0] OP_NOR = 8'h27;

endpackage

// File: rtl/uart_alu_interface_timeout_counter.sv
// Inter-byte inactivity counter. Counts while enabled, clears on request,
// and flags expiry combinationally on the cycle the limit is reached.
module timeout_counter #(
  parameter int TIMEOUT_CICLOS    = 1000000,
  parameter int CANT_BITS_TIMEOUT = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);
  import uart_alu_interface_pkg::*;

  localparam logic [CANT_BITS_TIMEOUT-1:0] LIMITE = CANT_BITS_TIMEOUT'(TIMEOUT_CICLOS - 1);

  logic [CANT_BITS_TIMEOUT-1:0] cuenta_q, cuenta_d;

  // A byte arriving on the limit cycle takes priority, so it masks expiry.
  assign expired_o = en_i && !clear_i && (cuenta_q == LIMITE);

  // Next count: clear when idle, on a byte or on expiry; otherwise saturate at the limit.
  always_comb begin
    cuenta_d = cuenta_q;
    if (!en_i || clear_i || expired_o) begin
      cuenta_d = '0;
    end else if (cuenta_q != LIMITE) begin
      cuenta_d = cuenta_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Sequencer between UART RX/TX and the ALU: gathers operand 1, operand 2 and
// opcode, gives the ALU one cycle to settle, then hands the result to UART TX.
module uart_alu_interface #(
  parameter int CANT_BUS_DATOS    = uart_alu_interface_pkg::CANT_BUS_DATOS,
  parameter int CANT_BITS_OPCODE  = uart_alu_interface_pkg::CANT_BITS_OPCODE,
  parameter int TIMEOUT_CICLOS    = 1000000,
  parameter int CANT_BITS_TIMEOUT = 20
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_rx_done,
  input  logic [CANT_BUS_DATOS-1:0]   i_data_rx,
  input  logic                        i_tx_done,
  input  logic [CANT_BUS_DATOS-1:0]   i_resultado_alu,
  output logic [CANT_BUS_DATOS-1:0]   o_operando_1,
  output logic [CANT_BUS_DATOS-1:0]   o_operando_2,
  output logic [CANT_BITS_OPCODE-1:0] o_opcode,
  output logic                        o_tx_start,
  output logic [CANT_BUS_DATOS-1:0]   o_data_tx,
  output logic                        o_error_timeout,
  output logic                        o_overrun
);
  import uart_alu_interface_pkg::*;

  estado_t                     estado_q;
  logic [CANT_BUS_DATOS-1:0]   operando_1_q;
  logic [CANT_BUS_DATOS-1:0]   operando_2_q;
  logic [CANT_BITS_OPCODE-1:0] opcode_q;
  logic [CANT_BUS_DATOS-1:0]   data_tx_q;
  logic                        tx_start_q;
  logic                        error_timeout_q;
  logic                        overrun_q;

  logic cuenta_en;
  logic expirado;

  // Only a partially received frame is subject to the inactivity timeout.
  assign cuenta_en = (estado_q == ESPERA_OP2) || (estado_q == ESPERA_OPCODE);

  timeout_counter #(
    .TIMEOUT_CICLOS    (TIMEOUT_CICLOS),
    .CANT_BITS_TIMEOUT (CANT_BITS_TIMEOUT)
  ) u_timeout (
    .clk_i     (i_clock),
    .rst_ni    (i_reset),
    .en_i      (cuenta_en),
    .clear_i   (i_rx_done),
    .expired_o (expirado)
  );

  // Frame sequencer with registered ALU inputs, TX byte and status pulses.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      estado_q        <= ESPERA_OP1;
      operando_1_q    <= '0;
      operando_2_q    <= '0;
      opcode_q        <= '0;
      data_tx_q       <= '0;
      tx_start_q      <= 1'b0;
      error_timeout_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      tx_start_q      <= 1'b0;
      error_timeout_q <= 1'b0;
      overrun_q       <= 1'b0;
      case (estado_q)
        ESPERA_OP1: begin
          if (i_rx_done) begin
            operando_1_q <= i_data_rx;
            estado_q     <= ESPERA_OP2;
          end
        end
        ESPERA_OP2: begin
          if (i_rx_done) begin
            operando_2_q <= i_data_rx;
            estado_q     <= ESPERA_OPCODE;
          end else if (expirado) begin
            error_timeout_q <= 1'b1;
            estado_q        <= ESPERA_OP1;
          end
        end
        ESPERA_OPCODE: begin
          if (i_rx_done) begin
            opcode_q <= i_data_rx[CANT_BITS_OPCODE-1:0];
            estado_q <= CALCULO;
          end else if (expirado) begin
            error_timeout_q <= 1'b1;
            estado_q        <= ESPERA_OP1;
          end
        end
        CALCULO: begin
          data_tx_q  <= i_resultado_alu;
          tx_start_q <= 1'b1;
          overrun_q  <= i_rx_done;
          estado_q   <= ESPERA_TX;
        end
        ESPERA_TX: begin
          overrun_q <= i_rx_done;
          if (i_tx_done) begin
            estado_q <= ESPERA_OP1;
          end
        end
        default: estado_q <= ESPERA_OP1;
      endcase
    end
  end

  assign o_operando_1    = operando_1_q;
  assign o_operando_2    = operando_2_q;
  assign o_opcode        = opcode_q;
  assign o_data_tx       = data_tx_q;
  assign o_tx_start      = tx_start_q;
  assign o_error_timeout = error_timeout_q;
  assign o_overrun       = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: plays UART RX/TX and a reference ALU.
module tb_uart_alu_interface;

  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         rx_done = 1'b0;
  logic         tx_done = 1'b0;
  logic [W-1:0] data_rx = '0;
  logic [W-1:0] res_alu;
  logic [W-1:0] op1, op2, opc, data_tx;
  logic         tx_start, err_to, overrun;

  int checks = 0;
  int errors = 0;

  uart_alu_interface #(
    .CANT_BUS_DATOS    (W),
    .CANT_BITS_OPCODE  (W),
    .TIMEOUT_CICLOS    (TO),
    .CANT_BITS_TIMEOUT (5)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_rx_done       (rx_done),
    .i_data_rx       (data_rx),
    .i_tx_done       (tx_done),
    .i_resultado_alu (res_alu),
    .o_operando_1    (op1),
    .o_operando_2    (op2),
    .o_opcode        (opc),
    .o_tx_start      (tx_start),
    .o_data_tx       (data_tx),
    .o_error_timeout (err_to),
    .o_overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Reference ALU, plain integer arithmetic on byte values.
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] op);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      8'h20: r = (ia + ib) % 256;
      8'h22: r = (ia - ib + 256) % 256;
      8'h24: r = ia & ib;
      8'h25: r = ia | ib;
      8'h26: r = ia ^ ib;
      8'h27: r = 255 - (ia | ib);
      8'h02: r = (ib > 7) ? 0 : ia / (1 << ib);
      8'h03: begin
        r = (ia >= 128) ? ia - 256 : ia;
        r = (ib > 7) ? ((r < 0) ? -1 : 0) : (r >>> ib);
        r = r & 255;
      end
      default: r = ia;
    endcase
    return W'(r);
  endfunction

  always_comb res_alu = alu_ref(op1, op2, opc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [W-1:0] b);
    rx_done = 1'b1;
    data_rx = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Entered on the negedge right after the opcode edge.
  task automatic finish_frame(input string tag, input logic [W-1:0] exp, input int tx_delay);
    chk({tag, " start_early"}, 32'(tx_start), 32'd0);
    @(negedge clk);
    chk({tag, " start"}, 32'(tx_start), 32'd1);
    chk({tag, " data"}, 32'(data_tx), 32'(exp));
    for (int i = 0; i < tx_delay + 1; i++) begin
      @(negedge clk);
      chk({tag, " start_width"}, 32'(tx_start), 32'd0);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] op;
    logic [W-1:0] res;
    int           tx_delay;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    int pulse_at;
    logic [W-1:0] a, b, op;
    logic [W-1:0] ops[9];

    tbl[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 2};
    tbl[1] = '{8'h03, 8'h05, 8'h22, 8'hFE, 50};
    tbl[2] = '{8'hF0, 8'h0F, 8'h25, 8'hFF, 1};
    tbl[3] = '{8'hCC, 8'hAA, 8'h24, 8'h88, 0};
    tbl[4] = '{8'hCC, 8'hAA, 8'h27, 8'h11, 3};
    tbl[5] = '{8'h80, 8'h03, 8'h02, 8'h10, 0};
    tbl[6] = '{8'h90, 8'h01, 8'h03, 8'hC8, 4};
    tbl[7] = '{8'h5A, 8'h77, 8'h00, 8'h5A, 1};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27, 8'h00};

    // Reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset op1", 32'(op1), 32'd0);
    chk("reset op2", 32'(op2), 32'd0);
    chk("reset opcode", 32'(opc), 32'd0);
    chk("reset outs", {28'd0, tx_start, err_to, overrun, 1'b0}, 32'd0);
    chk("reset data_tx", 32'(data_tx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].a);
      send_byte(tbl[i].b);
      send_byte(tbl[i].op);
      chk($sformatf("tbl%0d op1", i), 32'(op1), 32'(tbl[i].a));
      chk($sformatf("tbl%0d op2", i), 32'(op2), 32'(tbl[i].b));
      chk($sformatf("tbl%0d opcode", i), 32'(opc), 32'(tbl[i].op));
      finish_frame($sformatf("tbl%0d", i), tbl[i].res, tbl[i].tx_delay);
      chk($sformatf("tbl%0d hold op1", i), 32'(op1), 32'(tbl[i].a));
    end

    // Timeout after operand 1
    send_byte(8'hAA);
    pulses = 0;
    pulse_at = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (err_to) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk("timeout pulses", 32'(pulses), 32'd1);
    chk("timeout position", 32'(pulse_at), 32'd16);
    chk("timeout stale op1", 32'(op1), 32'hAA);
    send_byte(8'h80);
    send_byte(8'h02);
    send_byte(8'h03);
    finish_frame("after_timeout", 8'hE0, 2);

    // Overrun in CALCULO and ESPERA_TX, including alongside tx_done
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h20);
    send_byte(8'h55);
    chk("ovr calc start", 32'(tx_start), 32'd1);
    chk("ovr calc flag", 32'(overrun), 32'd1);
    chk("ovr calc data", 32'(data_tx), 32'h33);
    @(negedge clk);
    chk("ovr flag width", 32'(overrun), 32'd0);
    send_byte(8'h55);
    chk("ovr tx flag", 32'(overrun), 32'd1);
    chk("ovr op1 kept", 32'(op1), 32'h11);
    tx_done = 1'b1;
    send_byte(8'h55);
    tx_done = 1'b0;
    chk("ovr with tx_done", 32'(overrun), 32'd1);
    chk("ovr op1 kept2", 32'(op1), 32'h11);
    send_byte(8'h07);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    send_byte(8'h09);
    send_byte(8'h20);
    chk("post ovr op1", 32'(op1), 32'h07);
    finish_frame("post_ovr", 8'h10, 0);

    // Asynchronous reset mid-frame
    send_byte(8'h33);
    send_byte(8'h44);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset op1", 32'(op1), 32'd0);
    chk("midreset op2", 32'(op2), 32'd0);
    chk("midreset opcode", 32'(opc), 32'd0);
    chk("midreset data_tx", 32'(data_tx), 32'd0);
    chk("midreset flags", {29'd0, tx_start, err_to, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h0C);
    send_byte(8'h0A);
    send_byte(8'h26);
    finish_frame("post_reset", 8'h06, 1);

    // Byte on the expiry cycle wins over the timeout
    send_byte(8'h01);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (err_to) pulses++;
    end
    send_byte(8'h01);
    if (err_to) pulses++;
    chk("expiry byte op2", 32'(op2), 32'h01);
    repeat (3) begin
      @(negedge clk);
      if (err_to) pulses++;
    end
    chk("expiry no timeout", 32'(pulses), 32'd0);
    send_byte(8'h20);
    finish_frame("expiry_frame", 8'h02, 0);

    // Randomized frames against the reference model
    for (int n = 0; n < 40; n++) begin
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
      op = ops[$urandom_range(0, 8)];
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_byte(a);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      send_byte(b);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      send_byte(op);
      finish_frame($sformatf("rand%0d a=%0h b=%0h op=%0h", n, a, b, op),
                   alu_ref(a, b, op), int'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
